// File: rtl/trigger_pkg.sv
// Shared types for the ADC debug trigger path: sequencer state encoding and the
// per-lane trigger_bit mode codes.
package trigger_pkg;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_NUM_LANES = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

  typedef enum logic [2:0] {
    MODE_MASK       = 3'd0,
    MODE_LEVEL_HIGH = 3'd1,
    MODE_LEVEL_LOW  = 3'd2,
    MODE_RISE_EDGE  = 3'd3,
    MODE_FALL_EDGE  = 3'd4,
    MODE_BOTH_EDGE  = 3'd5
  } trigger_mode_e;

endpackage

// File: rtl/trigger_combine.sv
// Combinational AND/OR reduction of per-lane trigger_succeed over the enabled lanes.
// With no lanes enabled the combined hit is forced low in both modes.
module trigger_combine #(
  parameter int NUM_LANES = 16
) (
  input  logic [NUM_LANES-1:0] lane_succeed,
  input  logic [NUM_LANES-1:0] en,
  input  logic                 combine_or,
  output logic                 hit_c
);

  always_comb begin
    hit_c = 1'b0;
    if (|en) begin
      if (combine_or)
        hit_c = |(lane_succeed & en);
      else
        hit_c = &(lane_succeed | ~en);
    end
  end

endmodule

// File: rtl/trigger_seq_ctrl.sv
// Capture-window sequencer: arm -> pre-trigger fill -> wait for trigger -> post capture -> done.
// Optional WAIT-state timeout is compiled in when TRIG_TIMEOUT_EN is defined.
module trigger_seq_ctrl
  import trigger_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic                 combine_or,
  input  logic [CNT_W-1:0]     pre_len,
  input  logic [CNT_W-1:0]     post_len,
  input  logic [NUM_LANES-1:0] lane_succeed,
  input  logic                 data_vld,
`ifdef TRIG_TIMEOUT_EN
  input  logic [31:0]          timeout_len,
  output logic                 timeout,
`endif
  output logic                 capture_en,
  output logic                 trig_hit,
  output logic [CNT_W-1:0]     trig_pos,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  seq_state_e           state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [CNT_W-1:0]     cap_cnt, cap_cnt_nxt;
  logic [CNT_W-1:0]     pre_len_r, pre_len_nxt;
  logic [CNT_W-1:0]     post_len_r, post_len_nxt;
  logic [NUM_LANES-1:0] lane_en_r, lane_en_nxt;
  logic                 combine_or_r, combine_or_nxt;
  logic                 capture_en_nxt, trig_hit_nxt, busy_nxt, done_nxt;
  logic [CNT_W-1:0]     trig_pos_nxt;
  logic                 hit_c;
`ifdef TRIG_TIMEOUT_EN
  logic [31:0]          tmo_cnt, tmo_cnt_nxt;
  logic [31:0]          tmo_len_r, tmo_len_nxt;
  logic                 timeout_nxt;
`endif

  trigger_combine #(.NUM_LANES(NUM_LANES)) u_combine (
    .lane_succeed (lane_succeed),
    .en           (lane_en_r),
    .combine_or   (combine_or_r),
    .hit_c        (hit_c)
  );

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cap_cnt_nxt    = cap_cnt;
    pre_len_nxt    = pre_len_r;
    post_len_nxt   = post_len_r;
    lane_en_nxt    = lane_en_r;
    combine_or_nxt = combine_or_r;
    capture_en_nxt = 1'b0;
    trig_hit_nxt   = 1'b0;
    trig_pos_nxt   = trig_pos;
`ifdef TRIG_TIMEOUT_EN
    tmo_cnt_nxt    = tmo_cnt;
    tmo_len_nxt    = tmo_len_r;
    timeout_nxt    = 1'b0;
`endif

    case (state)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          pre_len_nxt    = pre_len;
          post_len_nxt   = post_len;
          lane_en_nxt    = lane_en;
          combine_or_nxt = combine_or;
          cnt_nxt        = '0;
          cap_cnt_nxt    = '0;
          trig_pos_nxt   = '0;
          state_nxt      = (pre_len != '0) ? ST_PRE : ST_WAIT;
`ifdef TRIG_TIMEOUT_EN
          tmo_len_nxt    = timeout_len;
          tmo_cnt_nxt    = '0;
`endif
        end
      end
      ST_PRE: begin
        if (data_vld) begin
          capture_en_nxt = 1'b1;
          cap_cnt_nxt    = sat_inc(cap_cnt);
          if (cnt + CNT_ONE == pre_len_r) begin
            cnt_nxt   = '0;
            state_nxt = ST_WAIT;
`ifdef TRIG_TIMEOUT_EN
            tmo_cnt_nxt = '0;
`endif
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      ST_WAIT: begin
`ifdef TRIG_TIMEOUT_EN
        tmo_cnt_nxt = tmo_cnt + 32'd1;
`endif
        if (data_vld) begin
          capture_en_nxt = 1'b1;
          cap_cnt_nxt    = sat_inc(cap_cnt);
        end
        if (data_vld && hit_c) begin
          trig_hit_nxt = 1'b1;
          trig_pos_nxt = cap_cnt;
          cnt_nxt      = '0;
          state_nxt    = (post_len_r != '0) ? ST_POST : ST_DONE;
        end
`ifdef TRIG_TIMEOUT_EN
        // A real trigger in the same cycle as expiry takes precedence.
        else if (tmo_len_r != '0 && tmo_cnt + 32'd1 == tmo_len_r) begin
          timeout_nxt  = 1'b1;
          trig_pos_nxt = '1;
          state_nxt    = ST_DONE;
        end
`endif
      end
      ST_POST: begin
        if (data_vld) begin
          capture_en_nxt = 1'b1;
          if (cnt + CNT_ONE == post_len_r) begin
            cnt_nxt   = '0;
            state_nxt = ST_DONE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Abort overrides arm and any transition decided above; trig_pos is preserved.
    if (abort) begin
      state_nxt      = ST_IDLE;
      capture_en_nxt = 1'b0;
      trig_hit_nxt   = 1'b0;
      trig_pos_nxt   = trig_pos;
`ifdef TRIG_TIMEOUT_EN
      timeout_nxt    = 1'b0;
`endif
    end

    busy_nxt = (state_nxt == ST_PRE) || (state_nxt == ST_WAIT) || (state_nxt == ST_POST);
    done_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cap_cnt      <= '0;
      pre_len_r    <= '0;
      post_len_r   <= '0;
      lane_en_r    <= '0;
      combine_or_r <= 1'b0;
      capture_en   <= 1'b0;
      trig_hit     <= 1'b0;
      trig_pos     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef TRIG_TIMEOUT_EN
      tmo_cnt      <= '0;
      tmo_len_r    <= '0;
      timeout      <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cap_cnt      <= cap_cnt_nxt;
      pre_len_r    <= pre_len_nxt;
      post_len_r   <= post_len_nxt;
      lane_en_r    <= lane_en_nxt;
      combine_or_r <= combine_or_nxt;
      capture_en   <= capture_en_nxt;
      trig_hit     <= trig_hit_nxt;
      trig_pos     <= trig_pos_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
`ifdef TRIG_TIMEOUT_EN
      tmo_cnt      <= tmo_cnt_nxt;
      tmo_len_r    <= tmo_len_nxt;
      timeout      <= timeout_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_trigger_seq_ctrl.sv
// Directed testbench for trigger_seq_ctrl; the timeout scenario is built only with TRIG_TIMEOUT_EN.
module tb_trigger_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] lane_en = '0;
  logic        combine_or = 1'b0;
  logic [15:0] pre_len = '0;
  logic [15:0] post_len = '0;
  logic [15:0] lane_succeed = '0;
  logic        data_vld = 1'b0;
  logic        capture_en, trig_hit, busy, done;
  logic [15:0] trig_pos;
`ifdef TRIG_TIMEOUT_EN
  logic [31:0] timeout_len = '0;
  logic        timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trigger_seq_ctrl #(.NUM_LANES(16), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .abort        (abort),
    .lane_en      (lane_en),
    .combine_or   (combine_or),
    .pre_len      (pre_len),
    .post_len     (post_len),
    .lane_succeed (lane_succeed),
    .data_vld     (data_vld),
`ifdef TRIG_TIMEOUT_EN
    .timeout_len  (timeout_len),
    .timeout      (timeout),
`endif
    .capture_en   (capture_en),
    .trig_hit     (trig_hit),
    .trig_pos     (trig_pos),
    .busy         (busy),
    .done         (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_seq(input logic [15:0] p, input logic [15:0] q,
                         input logic [15:0] en, input logic orm);
    pre_len = p; post_len = q; lane_en = en; combine_or = orm;
    data_vld = 1'b0; lane_succeed = '0; arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({capture_en, trig_hit, busy, done} !== 4'b0000 || trig_pos !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs cap/hit/busy/done=%b trig_pos=%h expected 0000/0000", {capture_en, trig_hit, busy, done}, trig_pos);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_or();
    int caps = 0;
    arm_seq(16'd4, 16'd3, 16'h0001, 1'b1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL t1_armed busy=%b done=%b expected 1 0", busy, done);
    end
    for (int i = 1; i <= 11; i++) begin
      data_vld = 1'b1;
      lane_succeed = (i == 8) ? 16'h0001 : 16'h0000;
      step();
      caps += capture_en;
      checks++;
      if (trig_hit !== (i == 8)) begin
        errors++; $display("FAIL t1_trig_hit sample=%0d got=%b expected %b", i, trig_hit, (i == 8));
      end
      if (i == 8) begin
        checks++;
        if (trig_pos !== 16'd7) begin
          errors++; $display("FAIL t1_trig_pos got=%0d expected 7", trig_pos);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL t1_done done=%b busy=%b expected 1 0", done, busy);
    end
    lane_succeed = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      step();
      caps += capture_en;
    end
    data_vld = 1'b0; lane_succeed = '0;
    checks++;
    if (caps != 11 || done !== 1'b1 || trig_pos !== 16'd7) begin
      errors++; $display("FAIL t1_capture_count caps=%0d done=%b pos=%0d expected 11 1 7", caps, done, trig_pos);
    end
  endtask

  task automatic test_and_combine();
    logic [15:0] pat [3];
    pat[0] = 16'h0005; pat[1] = 16'h0001; pat[2] = 16'h0003;
    arm_seq(16'd0, 16'd0, 16'h0003, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL t2_armed busy=%b done=%b expected 1 0", busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      data_vld = 1'b1;
      lane_succeed = pat[i];
      step();
      checks++;
      if (trig_hit !== (i == 2)) begin
        errors++; $display("FAIL t2_trig_hit step=%0d got=%b expected %b", i, trig_hit, (i == 2));
      end
    end
    data_vld = 1'b0; lane_succeed = '0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || trig_pos !== 16'd2 || capture_en !== 1'b1) begin
      errors++; $display("FAIL t2_done done=%b busy=%b pos=%0d cap=%b expected 1 0 2 1", done, busy, trig_pos, capture_en);
    end
  endtask

  task automatic test_hit_during_pre();
    arm_seq(16'd5, 16'd1, 16'h0002, 1'b1);
    data_vld = 1'b1;
    lane_succeed = 16'h0002;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if (trig_hit !== (i == 6)) begin
        errors++; $display("FAIL t3_trig_hit sample=%0d got=%b expected %b", i, trig_hit, (i == 6));
      end
    end
    checks++;
    if (trig_pos !== 16'd5) begin
      errors++; $display("FAIL t3_trig_pos got=%0d expected 5", trig_pos);
    end
    step();
    data_vld = 1'b0; lane_succeed = '0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL t3_done got=%b expected 1", done);
    end
  endtask

  task automatic test_abort_arm();
    arm_seq(16'd1, 16'd10, 16'h0001, 1'b1);
    data_vld = 1'b1;
    lane_succeed = 16'h0000; step();
    lane_succeed = 16'h0001; step();
    checks++;
    if (trig_hit !== 1'b1 || trig_pos !== 16'd1) begin
      errors++; $display("FAIL t4_hit hit=%b pos=%0d expected 1 1", trig_hit, trig_pos);
    end
    lane_succeed = '0; step();
    abort = 1'b1; arm = 1'b1;
    step();
    abort = 1'b0; arm = 1'b0;
    checks++;
    if (capture_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || trig_pos !== 16'd1) begin
      errors++; $display("FAIL t4_abort cap=%b busy=%b done=%b pos=%0d expected 0 0 0 1", capture_en, busy, done, trig_pos);
    end
    step();
    data_vld = 1'b0;
    checks++;
    if (capture_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL t4_idle cap=%b busy=%b done=%b expected 0 0 0", capture_en, busy, done);
    end
  endtask

  task automatic test_vld_gaps();
    int vcount = 0;
    logic vld;
    arm_seq(16'd2, 16'd2, 16'h0001, 1'b1);
    for (int k = 0; k < 15; k++) begin
      vld = (k % 3 == 2);
      if (vld) vcount++;
      data_vld = vld;
      lane_succeed = vld ? ((vcount == 3) ? 16'h0001 : 16'h0000) : 16'h0001;
      // Re-arm with different length while busy must be ignored
      arm = (k == 0);
      pre_len = 16'd7;
      step();
      arm = 1'b0;
      checks++;
      if (capture_en !== vld || trig_hit !== (vld && vcount == 3) || done !== (k == 14)) begin
        errors++;
        $display("FAIL t5_cycle k=%0d cap=%b hit=%b done=%b expected %b %b %b", k, capture_en, trig_hit, done,
                 vld, (vld && vcount == 3), (k == 14));
      end
    end
    data_vld = 1'b0; lane_succeed = '0;
    checks++;
    if (trig_pos !== 16'd2) begin
      errors++; $display("FAIL t5_trig_pos got=%0d expected 2", trig_pos);
    end
  endtask

  task automatic test_async_reset();
    arm_seq(16'd3, 16'd1, 16'h0001, 1'b1);
    data_vld = 1'b1;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({capture_en, trig_hit, busy, done} !== 4'b0000 || trig_pos !== 16'h0) begin
      errors++; $display("FAIL async_reset cap/hit/busy/done=%b pos=%h expected 0000/0000", {capture_en, trig_hit, busy, done}, trig_pos);
    end
    data_vld = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset_idle busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

`ifdef TRIG_TIMEOUT_EN
  task automatic test_timeout();
    int seen = 0;
    timeout_len = 32'd100;
    arm_seq(16'd0, 16'd2, 16'h0001, 1'b1);
    for (int i = 1; i <= 150; i++) begin
      step();
      if (trig_hit) begin
        checks++; errors++; $display("FAIL t6_unexpected_hit cycle=%0d", i);
      end
      if (timeout) begin
        seen = i;
        break;
      end
    end
    checks++;
    if (seen != 100) begin
      errors++; $display("FAIL t6_timeout_cycle got=%0d expected 100", seen);
    end
    checks++;
    if (trig_pos !== 16'hFFFF || done !== 1'b1) begin
      errors++; $display("FAIL t6_state pos=%h done=%b expected ffff 1", trig_pos, done);
    end
    step();
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL t6_pulse timeout=%b expected 0", timeout);
    end
    timeout_len = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_or();
    test_and_combine();
    test_hit_during_pre();
    test_abort_arm();
    test_vld_gaps();
    test_async_reset();
`ifdef TRIG_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
